// File: rtl/freq_meter_pkg.sv
// Shared types and default sizing for the frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        REPORT
    } meter_state_t;

    localparam int GATE_CYCLES_DEFAULT = 100_000_000;
    localparam int COUNT_W_DEFAULT     = 32;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into the clk domain and emits a registered
// one-cycle pulse on each rising edge (usable for button inputs as well).
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sig,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_delay;
    logic                   r_edge;

    // Edge pulse is registered, so a rise shows up SYNC_STAGES+1 clk edges later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_delay <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_delay <= r_sync[SYNC_STAGES-1];
            r_edge  <= r_sync[SYNC_STAGES-1] & ~r_delay;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of i_sig_in over a GATE_CYCLES window of clk cycles.
// Define FREQ_METER_PERIOD_EN to add o_period_out (last edge-to-edge interval).
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
    parameter int COUNT_W     = COUNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_sig_in,
    input  logic               i_start,
    input  logic               i_continuous,
    output logic               o_busy,
    output logic [COUNT_W-1:0] o_count_out,
    output logic               o_count_valid,
    output logic               o_overflow
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [COUNT_W-1:0] o_period_out
`endif
);

    localparam int                 GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    meter_state_t       r_state;
    meter_state_t       w_next_state;
    logic [GATE_W-1:0]  r_gate_ctr;
    logic [COUNT_W-1:0] r_edge_ctr;
    logic [COUNT_W-1:0] r_count_out;
    logic               r_ovf;
    logic               r_overflow;
    logic               w_edge;
    logic               w_last;
    logic               w_edge_sat;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .i_sig  (i_sig_in),
        .o_edge (w_edge)
    );

    assign w_last     = (r_state == GATE) && (r_gate_ctr == GATE_LAST);
    assign w_edge_sat = w_edge && (r_edge_ctr == COUNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // start arriving outside IDLE is simply not looked at, so it is never queued.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start || i_continuous) w_next_state = GATE;
            GATE:    if (w_last) w_next_state = REPORT;
            REPORT:  w_next_state = i_continuous ? GATE : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Counters are held at zero outside GATE, which also clears them on every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gate_ctr  <= '0;
            r_edge_ctr  <= '0;
            r_ovf       <= 1'b0;
            r_count_out <= '0;
            r_overflow  <= 1'b0;
        end else if (r_state != GATE) begin
            r_gate_ctr <= '0;
            r_edge_ctr <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_gate_ctr <= r_gate_ctr + GATE_W'(1);
            if (w_edge) begin
                if (w_edge_sat) r_ovf <= 1'b1;
                else            r_edge_ctr <= r_edge_ctr + COUNT_W'(1);
            end
            if (w_last) begin
                r_count_out <= (w_edge && !w_edge_sat) ? r_edge_ctr + COUNT_W'(1) : r_edge_ctr;
                r_overflow  <= r_ovf | w_edge_sat;
            end
        end
    end

    assign o_busy        = (r_state != IDLE);
    assign o_count_valid = (r_state == REPORT);
    assign o_count_out   = r_count_out;
    assign o_overflow    = r_overflow;

`ifdef FREQ_METER_PERIOD_EN
    logic [COUNT_W-1:0] r_period_ctr;
    logic [COUNT_W-1:0] r_period_last;
    logic [COUNT_W-1:0] r_period_out;
    logic               r_seen_edge;

    // r_period_ctr restarts at 1 on each edge, so at the next edge it equals the interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period_ctr  <= '0;
            r_period_last <= '0;
            r_period_out  <= '0;
            r_seen_edge   <= 1'b0;
        end else if (r_state != GATE) begin
            r_period_ctr  <= '0;
            r_period_last <= '0;
            r_seen_edge   <= 1'b0;
        end else begin
            if (w_edge) begin
                r_seen_edge  <= 1'b1;
                r_period_ctr <= COUNT_W'(1);
                if (r_seen_edge) r_period_last <= r_period_ctr;
            end else if (r_period_ctr != COUNT_MAX) begin
                r_period_ctr <= r_period_ctr + COUNT_W'(1);
            end
            if (w_last)
                r_period_out <= (w_edge && r_seen_edge) ? r_period_ctr : r_period_last;
        end
    end

    assign o_period_out = r_period_out;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: expected reports are queued at stimulus time
// and popped by per-instance monitors whenever o_count_valid is seen.
module tb_freq_meter;

    localparam int GATE = 1000;

    typedef struct {
        int count;
        bit ovf;
        int period;
        int atCycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sigIn;
    logic        start;
    logic        start4;
    logic        continuous;
    logic        busy, countValid, overflow;
    logic [31:0] countOut;
    logic        busy4, countValid4, overflow4;
    logic [3:0]  countOut4;
`ifdef FREQ_METER_PERIOD_EN
    logic [31:0] periodOut;
    logic [3:0]  periodOut4;
`endif

    exp_t q[$];
    exp_t q4[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   cycle       = 0;
    int   sigPeriod   = 0;
    int   phase       = 0;

    freq_meter #(.GATE_CYCLES(GATE), .COUNT_W(32), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_sig_in      (sigIn),
        .i_start       (start),
        .i_continuous  (continuous),
        .o_busy        (busy),
        .o_count_out   (countOut),
        .o_count_valid (countValid),
        .o_overflow    (overflow)
`ifdef FREQ_METER_PERIOD_EN
        ,
        .o_period_out  (periodOut)
`endif
    );

    freq_meter #(.GATE_CYCLES(GATE), .COUNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk           (clk),
        .reset         (reset),
        .i_sig_in      (sigIn),
        .i_start       (start4),
        .i_continuous  (1'b0),
        .o_busy        (busy4),
        .o_count_out   (countOut4),
        .o_count_valid (countValid4),
        .o_overflow    (overflow4)
`ifdef FREQ_METER_PERIOD_EN
        ,
        .o_period_out  (periodOut4)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Periodic test signal: high for the first half of each period.
    always @(negedge clk) begin
        if (sigPeriod == 0) begin
            sigIn = 1'b0;
            phase = 0;
        end else begin
            if (phase >= sigPeriod) phase = 0;
            sigIn = (phase < sigPeriod / 2);
            phase = phase + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Main instance monitor.
    always @(negedge clk) begin : monMain
        exp_t e;
        if (!reset && countValid === 1'b1) begin
            if (q.size() == 0) begin
                checkOutput("unexpected_valid", 64'(countValid), 64'd0);
            end else begin
                e = q.pop_front();
                checkOutput("count", 64'(countOut), 64'(e.count));
                checkOutput("overflow", 64'(overflow), 64'(e.ovf));
                if (e.atCycle >= 0) checkOutput("valid_cycle", 64'(cycle), 64'(e.atCycle));
`ifdef FREQ_METER_PERIOD_EN
                checkOutput("period", 64'(periodOut), 64'(e.period));
`endif
            end
        end
    end

    // Narrow-counter instance monitor.
    always @(negedge clk) begin : monFour
        exp_t e;
        if (!reset && countValid4 === 1'b1) begin
            if (q4.size() == 0) begin
                checkOutput("unexpected_valid4", 64'(countValid4), 64'd0);
            end else begin
                e = q4.pop_front();
                checkOutput("count4", 64'(countOut4), 64'(e.count));
                checkOutput("overflow4", 64'(overflow4), 64'(e.ovf));
                if (e.atCycle >= 0) checkOutput("valid_cycle4", 64'(cycle), 64'(e.atCycle));
`ifdef FREQ_METER_PERIOD_EN
                checkOutput("period4", 64'(periodOut4), 64'(e.period));
`endif
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int period);
        sigPeriod = period;
        waitCycles(3 * period + 10);
    endtask

    task automatic pushExpect(input bit toFour, input int count, input bit ovf, input int period, input int offset);
        exp_t e;
        e.count   = count;
        e.ovf     = ovf;
        e.period  = period;
        e.atCycle = cycle + offset;
        if (toFour) q4.push_back(e);
        else        q.push_back(e);
    endtask

    task automatic pulseStart(input bit toFour);
        if (toFour) start4 = 1'b1;
        else        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((q.size() != 0 || q4.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("queue_drained", 64'(q.size() + q4.size()), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        start4     = 1'b0;
        continuous = 1'b0;
        waitCycles(3);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_count", 64'(countOut), 64'd0);
        checkOutput("reset_valid", 64'(countValid), 64'd0);
        checkOutput("reset_overflow", 64'(overflow), 64'd0);
        checkOutput("reset_count4", 64'(countOut4), 64'd0);
        reset = 1'b0;

        // Period 10 single shot: 100 edges.
        applyStimulus(10);
        pushExpect(0, 100, 0, 10, GATE + 1);
        pulseStart(0);
        waitCycles(10);
        checkOutput("busy_in_window", 64'(busy), 64'd1);
        waitDrain(GATE + 50);
        waitCycles(2);
        checkOutput("busy_after_report", 64'(busy), 64'd0);

        // Idle-low input: zero edges, valid exactly GATE+1 cycles after start.
        applyStimulus(0);
        pushExpect(0, 0, 0, 0, GATE + 1);
        pulseStart(0);
        waitDrain(GATE + 50);

        // 4-bit counter saturates with 250 edges, then clears for a quiet window.
        applyStimulus(4);
        pushExpect(1, 15, 1, 4, GATE + 1);
        pulseStart(1);
        waitDrain(GATE + 50);
        applyStimulus(0);
        pushExpect(1, 0, 0, 0, GATE + 1);
        pulseStart(1);
        waitDrain(GATE + 50);

        // Continuous mode, three windows, dropped midway through the third.
        applyStimulus(20);
        pushExpect(0, 50, 0, 20, GATE + 1);
        pushExpect(0, 50, 0, 20, 2 * (GATE + 1));
        pushExpect(0, 50, 0, 20, 3 * (GATE + 1));
        continuous = 1'b1;
        waitCycles(2 * (GATE + 1) + 500);
        continuous = 1'b0;
        waitDrain(GATE);
        waitCycles(3);
        checkOutput("busy_after_continuous", 64'(busy), 64'd0);
        waitCycles(GATE + 100);

        // Period 25: 40 edges.
        applyStimulus(25);
        pushExpect(0, 40, 0, 25, GATE + 1);
        pulseStart(0);
        waitDrain(GATE + 50);

        // A second start mid-window must not produce a second report.
        applyStimulus(10);
        pushExpect(0, 100, 0, 10, GATE + 1);
        pulseStart(0);
        waitCycles(199);
        pulseStart(0);
        waitDrain(GATE + 50);
        waitCycles(GATE + 100);

        // Async reset in the middle of a window discards it.
        pulseStart(0);
        waitCycles(500);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_count", 64'(countOut), 64'd0);
        checkOutput("midreset_valid", 64'(countValid), 64'd0);
        checkOutput("midreset_overflow", 64'(overflow), 64'd0);
`ifdef FREQ_METER_PERIOD_EN
        checkOutput("midreset_period", 64'(periodOut), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        waitCycles(GATE + 500);
        checkOutput("busy_after_midreset", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
